// File: rtl/resp_demux_pkg.sv
// Shared constants for the result demultiplexer: default geometry and the
// fixed destination indices used by the pipeline consumers.
package resp_demux_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int N_OUT_DEF  = 4;
  localparam int SEL_W_DEF  = 2;
  localparam int CNT_W_DEF  = 8;

  localparam int DST_IF  = 0;
  localparam int DST_LD  = 1;
  localparam int DST_CP0 = 2;
  localparam int DST_FWD = 3;

endpackage

// File: rtl/resp_demux_slot.sv
// One-entry output buffer for a single consumer. It loads a beat, holds it
// until drained, and is cleared by flush.
module resp_demux_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              load,
  input  logic              drain,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Load wins over drain so a same-cycle drain and refill keeps the slot full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the payload register is reset too, so out_data reads zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/resp_demux.sv
// 1-to-N result router: steers each accepted producer beat into a one-entry
// slot for its destination and counts beats whose select is out of range.
module resp_demux
  import resp_demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_OUT  = N_OUT_DEF,
  parameter int SEL_W  = SEL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic                    drop_pulse,
  output logic [CNT_W-1:0]        drop_cnt
);

  localparam logic [SEL_W:0] N_OUT_L = (SEL_W+1)'(N_OUT);

  logic             sel_in_range;
  logic             drop_accept;
  logic [N_OUT-1:0] load;
  logic             drop_pulse_q, drop_pulse_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  assign sel_in_range = {1'b0, in_sel} < N_OUT_L;

  // in_ready looks only at the selected slot and never at in_valid; the
  // discard path is always ready except under flush.
  always_comb begin
    in_ready = 1'b0;
    load     = '0;
    if (!flush) begin
      if (!sel_in_range) in_ready = 1'b1;
      for (int d = 0; d < N_OUT; d++) begin
        if (in_sel == SEL_W'(d)) begin
          in_ready = !out_valid[d] || out_ready[d];
          load[d]  = in_valid && (!out_valid[d] || out_ready[d]);
        end
      end
    end
  end

  assign drop_accept = in_valid && !flush && !sel_in_range;

  always_comb begin
    drop_pulse_d = drop_accept;
    drop_cnt_d   = drop_cnt_q;
    if (drop_accept && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      drop_pulse_q <= drop_pulse_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign drop_pulse = drop_pulse_q;
  assign drop_cnt   = drop_cnt_q;

  for (genvar d = 0; d < N_OUT; d++) begin : g_slot
    resp_demux_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk    (clk),
      .resetn (resetn),
      .flush  (flush),
      .load   (load[d]),
      .drain  (out_valid[d] & out_ready[d]),
      .data_i (in_data),
      .valid_o(out_valid[d]),
      .data_o (out_data[d*DATA_W +: DATA_W])
    );
  end

endmodule
